// File: rtl/reg_bus_pkg.sv
// Shared reg_bus types: op encoding and the byte-strobe to bit-mask helper.
package reg_bus_pkg;
  typedef enum logic [1:0] {NOP = 2'd0, RD = 2'd1, WR = 2'd2, SET = 2'd3} op_e;

  localparam int MAX_DW = 256;

  // Callers zero-extend their strobes and cast the result down to their width.
  function automatic logic [MAX_DW-1:0] strb_to_mask(input logic [MAX_DW/8-1:0] wstrb);
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_DW/8; b++) m[b*8 +: 8] = {8{wstrb[b]}};
    return m;
  endfunction
endpackage

// File: rtl/reg_bank_decode.sv
// Address decode: one-hot RW select, STATUS hit, out-of-range flag.
module reg_bank_decode #(
  parameter int AWIDTH   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic [AWIDTH-1:0]   i_addr,
  output logic [NUM_REGS-2:0] o_rw_sel,
  output logic                o_is_status,
  output logic                o_is_invalid
);
  // One extra bit so NUM_REGS == 2**AWIDTH still compares correctly.
  localparam logic [AWIDTH:0] LP_STATUS = (AWIDTH+1)'(NUM_REGS-1);
  localparam logic [AWIDTH:0] LP_NUM    = (AWIDTH+1)'(NUM_REGS);

  logic [AWIDTH:0] w_addr;
  assign w_addr       = {1'b0, i_addr};
  assign o_is_status  = (w_addr == LP_STATUS);
  assign o_is_invalid = (w_addr >= LP_NUM);

  for (genvar i = 0; i < NUM_REGS-1; i++) begin : g_sel
    assign o_rw_sel[i] = (i_addr == AWIDTH'(i));
  end
endmodule

// File: rtl/reg_bank.sv
// Register bank: NUM_REGS-1 RW regs with byte strobes and bit-set, plus a RO STATUS
// reg exposing a saturating error counter. One op per cycle, registered response.
module reg_bank
  import reg_bus_pkg::*;
#(
  parameter int                DWIDTH    = 32,
  parameter int                AWIDTH    = 8,
  parameter int                NUM_REGS  = 4,
  parameter logic [DWIDTH-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  op_e                 reg_op,
  input  logic [AWIDTH-1:0]   reg_addr,
  input  logic [DWIDTH-1:0]   reg_wdata,
  input  logic [DWIDTH/8-1:0] reg_wstrb,
  output logic [DWIDTH-1:0]   reg_rdata,
  output logic                rsp_valid,
  output logic                rsp_err
);
  if (DWIDTH % 8 != 0 || DWIDTH > MAX_DW) begin : g_bad_dw
    $error("reg_bank: DWIDTH must be a multiple of 8 and <= %0d", MAX_DW);
  end
  if (NUM_REGS < 2 || NUM_REGS > 2**AWIDTH) begin : g_bad_nr
    $error("reg_bank: NUM_REGS out of range");
  end
  if (CNT_W > DWIDTH) begin : g_bad_cw
    $error("reg_bank: CNT_W must be <= DWIDTH");
  end

  logic [NUM_REGS-2:0]              w_rw_sel;
  logic                             w_is_status;
  logic                             w_is_invalid;
  logic [DWIDTH-1:0]                w_mask;
  logic                             w_err;
  logic [DWIDTH-1:0]                w_rd_rw;
  logic [NUM_REGS-2:0][DWIDTH-1:0]  r_regs;
  logic [CNT_W-1:0]                 r_err_cnt;

  reg_bank_decode #(.AWIDTH(AWIDTH), .NUM_REGS(NUM_REGS)) u_dec (
    .i_addr      (reg_addr),
    .o_rw_sel    (w_rw_sel),
    .o_is_status (w_is_status),
    .o_is_invalid(w_is_invalid)
  );

  assign w_mask = DWIDTH'(strb_to_mask((MAX_DW/8)'(reg_wstrb)));
  assign w_err  = (reg_op != NOP) && (w_is_invalid || (reg_op == SET && w_is_status));

  always_comb begin
    w_rd_rw = '0;
    for (int i = 0; i < NUM_REGS-1; i++)
      if (w_rw_sel[i]) w_rd_rw = w_rd_rw | r_regs[i];
  end

  for (genvar i = 0; i < NUM_REGS-1; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_regs[i] <= RESET_VAL;
      else if (w_rw_sel[i] && reg_op == WR) r_regs[i] <= (r_regs[i] & ~w_mask) | (reg_wdata & w_mask);
      else if (w_rw_sel[i] && reg_op == SET) r_regs[i] <= r_regs[i] | (reg_wdata & w_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_err) begin
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end else if (reg_op == WR && w_is_status) begin
      r_err_cnt <= '0;
    end
  end

  // rdata only moves on RD; invalid reads return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_rdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (reg_op != NOP);
      rsp_err   <= w_err;
      if (reg_op == RD) begin
        if (w_is_invalid)     reg_rdata <= '0;
        else if (w_is_status) reg_rdata <= DWIDTH'(r_err_cnt);
        else                  reg_rdata <= w_rd_rw;
      end
    end
  end
endmodule
